xnor_popcount_acc: RTL and testbench
====================================

Name: xnor_popcount_acc

Overview:
- Downstream consumer of the binarization stage. Takes binarized activation vectors (bit 1 = +1, bit 0 = -1) and matching binary weight vectors.
- Computes the ±1 dot product over a fixed-length frame of beats using XNOR + popcount accumulation.
- Emits the signed sum plus a re-binarized sign bit for the next BNN layer of the VAD datapath.
- Valid/ready streaming on both sides; one result per frame.

Parameters:
- WIDTH, 32, bits per beat (activations and weights each).
- BEATS, 8, beats per frame; must be >= 1.
- CNT_W (localparam), $clog2(WIDTH*BEATS+1), match-count width; 9 at defaults.
- SUM_W (localparam), CNT_W+1, signed result width; 10 at defaults.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  beat valid.
- in_ready  output  1  stage can accept a beat.
- in_act  input  WIDTH  binarized activations.
- in_wgt  input  WIDTH  binary weights.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_sum  output  SUM_W  signed sum = 2*matches - WIDTH*BEATS.
- out_bit  output  1  1 when the sign test passes (see Optional Feature), else 0.
- busy  output  1  high when the frame is partially accumulated or a result is held.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, beat_cnt=0, match_acc=0, out_valid=0, out_sum=0, out_bit=0, busy=0.
- Reset overrides everything, including mid-frame and while a result is held. A partial frame is discarded with no output.
- Beat transfer occurs on any edge where in_valid && in_ready. Per-beat matches = popcount(~(in_act ^ in_wgt)), range 0..WIDTH.
- in_ready = (state==IDLE || state==ACC). It is combinational from state only, never from in_valid.
- FSM:
  - IDLE: on a transfer, match_acc = beat matches, beat_cnt = 1, go to ACC. If BEATS==1, go directly to OUT.
  - ACC: on a transfer, match_acc += beat matches and beat_cnt++. When the accepted beat is number BEATS (beat_cnt==BEATS-1 before the increment), go to OUT. Without a transfer, hold all state.
  - OUT: out_valid=1. out_sum and out_bit are registered on the edge that enters OUT and held stable until the handshake. On out_valid && out_ready, clear out_valid, beat_cnt and match_acc, and go to IDLE.
- No input is accepted in OUT: in_ready=0. A new frame can start the cycle after the output handshake; throughput is BEATS+1 cycles per frame with no stalls.
- Latency: out_valid is high in the cycle after the last beat's transfer edge.
- Arithmetic:
  - match_acc is unsigned CNT_W and never overflows by construction.
  - out_sum = (match_acc_final << 1) - WIDTH*BEATS in SUM_W two's complement.
  - Range is -WIDTH*BEATS .. +WIDTH*BEATS (-256..256 at defaults).
- busy = (state != IDLE).
- in_act and in_wgt are don't-care when in_valid=0. X values there must not propagate into state.

Optional Feature:
- Macro XNOR_ACC_THRESH_EN.
- Defined:
  - Adds input port thresh (signed SUM_W), sampled on the edge entering OUT.
  - out_bit = (out_sum >= thresh). This folds batch-norm into a threshold.
  - thresh is ignored at all other times.
- Undefined:
  - No thresh port.
  - out_bit = (out_sum >= 0); a zero sum maps to +1, matching the binarizer's convention.

Test Plan:
- Reset, then 8 beats with in_act=in_wgt=32'hA5A5A5A5, out_ready=1 -> out_valid in the cycle after beat 8; out_sum=+256; out_bit=1; returns to IDLE.
- 8 beats with in_act=32'hFFFFFFFF, in_wgt=32'h00000000 -> out_sum=-256; out_bit=0.
- 8 beats with in_act=32'h0000FFFF, in_wgt=32'hFFFFFFFF (16 matches per beat) -> out_sum=0; out_bit=1 (macro undefined).
- Frame of all-match beats with in_valid toggled 1/0 between beats, and out_ready held 0 for 5 cycles after out_valid:
  - out_sum stays +256 and in_ready=0 throughout the stall.
  - The result is released on the first out_ready=1.
  - The next frame's first beat is accepted the following cycle.
- rst pulsed after 4 accepted beats, then a full new all-mismatch frame -> no output from the aborted frame; next out_sum=-256.
- With XNOR_ACC_THRESH_EN defined, 12 matches per beat (out_sum=-64):
  - thresh=-64 gives out_bit=1.
  - thresh=-63 gives out_bit=0.

Source files
------------

// File: rtl/xnor_popcount_acc.sv
// xnor_popcount_acc
//   Accumulates the +/-1 dot product of binarized activations and binary
//   weights over a frame of BEATS beats. Each beat contributes
//   popcount(~(act ^ wgt)) matches. At frame end it emits
//   sum = 2*matches - WIDTH*BEATS and a re-binarized sign bit.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   beat handshake; in_ready depends only on state
//   in_act, in_wgt      WIDTH-bit activation / weight beat
//   thresh              (XNOR_ACC_THRESH_EN only) signed compare level,
//                       sampled on the edge that enters OUT
//   out_valid/out_ready result handshake
//   out_sum             signed frame sum, SUM_W bits
//   out_bit             out_sum >= thresh (or >= 0 without the macro)
//   busy                frame partially accumulated or result held
//
// Build option: define XNOR_ACC_THRESH_EN to add the thresh port.
module xnor_popcount_acc #(
  parameter  int WIDTH = 32,
  parameter  int BEATS = 8,
  localparam int CNT_W = $clog2(WIDTH*BEATS+1),
  localparam int SUM_W = CNT_W + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_act,
  input  logic [WIDTH-1:0]        in_wgt,
`ifdef XNOR_ACC_THRESH_EN
  input  logic signed [SUM_W-1:0] thresh,
`endif
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [SUM_W-1:0] out_sum,
  output logic                    out_bit,
  output logic                    busy
);

  localparam int              BC_W       = $clog2(BEATS+1);
  localparam logic [SUM_W-1:0] FRAME_BITS = SUM_W'(WIDTH*BEATS);
  localparam logic [BC_W-1:0]  LAST_IDX   = BC_W'(BEATS-1);

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

  state_t                   state, state_nxt;
  logic [BC_W-1:0]          beat_cnt;
  logic [CNT_W-1:0]         match_acc, beat_match, acc_nxt;
  logic [WIDTH-1:0]         agree;
  logic                     xfer, last_beat, bit_nxt;
  logic signed [SUM_W-1:0]  sum_nxt;

  assign in_ready  = (state == IDLE) || (state == ACC);
  assign out_valid = (state == OUT);
  assign busy      = (state != IDLE);
  assign xfer      = in_valid && in_ready;

  // Per-beat match count plus the would-be frame result if this beat ends it.
  always_comb begin
    agree      = ~(in_act ^ in_wgt);
    beat_match = '0;
    for (int i = 0; i < WIDTH; i++) beat_match += CNT_W'(agree[i]);
    // IDLE starts a fresh frame, so the old accumulator is not added.
    acc_nxt   = (state == ACC) ? match_acc + beat_match : beat_match;
    last_beat = (state == IDLE) ? (BEATS == 1) : (beat_cnt == LAST_IDX);
    // 2*m fits unsigned in SUM_W; the modular subtract lands on the
    // correct two's-complement value over -WIDTH*BEATS..+WIDTH*BEATS.
    sum_nxt   = $signed({acc_nxt, 1'b0} - FRAME_BITS);
`ifdef XNOR_ACC_THRESH_EN
    bit_nxt   = (sum_nxt >= thresh);
`else
    // Zero maps to +1, same as the upstream binarizer.
    bit_nxt   = ~sum_nxt[SUM_W-1];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (xfer) state_nxt = last_beat ? OUT : ACC;
      ACC:     if (xfer && last_beat) state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath only moves on a transfer, so X on idle data lanes never
  // reaches the accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt  <= '0;
      match_acc <= '0;
      out_sum   <= '0;
      out_bit   <= 1'b0;
    end else begin
      if (xfer) begin
        match_acc <= acc_nxt;
        beat_cnt  <= (state == IDLE) ? BC_W'(1) : beat_cnt + BC_W'(1);
        if (last_beat) begin
          out_sum <= sum_nxt;
          out_bit <= bit_nxt;
        end
      end
      if (out_valid && out_ready) begin
        beat_cnt  <= '0;
        match_acc <= '0;
      end
    end
  end

endmodule

// File: tb/tb_xnor_popcount_acc.sv
module tb_xnor_popcount_acc;
  localparam int WIDTH = 32;
  localparam int BEATS = 8;
  localparam int SUM_W = 10;

  logic                    clk = 1'b0;
  logic                    rst, in_valid, in_ready, out_valid, out_ready, out_bit, busy;
  logic [WIDTH-1:0]        in_act, in_wgt;
  logic signed [SUM_W-1:0] out_sum;
`ifdef XNOR_ACC_THRESH_EN
  logic signed [SUM_W-1:0] thresh;
`endif

  xnor_popcount_acc #(.WIDTH(WIDTH), .BEATS(BEATS)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_act(in_act), .in_wgt(in_wgt),
`ifdef XNOR_ACC_THRESH_EN
    .thresh(thresh),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_bit(out_bit), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0]   act;
    logic [WIDTH-1:0]   wgt;
    logic signed [31:0] sum;
    logic               b;
  } vec_t;

  typedef struct {
    logic signed [31:0] sum;
    logic               b;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  vec_t vecs[8];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic push_exp(input logic signed [31:0] s, input logic b);
    exp_t x;
    x.sum = s;
    x.b   = b;
    sb.push_back(x);
  endtask

  // Scoreboard: compare on every result handshake.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      chk("result_expected", (sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("out_sum", out_sum, e.sum);
        chk("out_bit", out_bit, e.b);
      end
    end
  end

  // Present nb beats; gap idle cycles between beats. Returns at
  // (last transfer edge + 1). first_wait = cycles until beat 0 accepted.
  task automatic send_frame(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] w,
                            input int nb, input int gap, output int first_wait);
    first_wait = 0;
    for (int b = 0; b < nb; b++) begin
      int   t;
      logic ok;
      in_valid = 1'b1;
      in_act   = a;
      in_wgt   = w;
      t        = 0;
      do begin
        @(negedge clk);
        ok = in_ready;
        @(posedge clk);
        #1;
        t++;
      end while (!ok && t < 50);
      chk("beat_accept", ok, 1);
      if (b == 0) first_wait = t;
      in_valid = 1'b0;
      in_act   = 'x;
      in_wgt   = 'x;
      if (b != nb - 1) repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic after_frame();
    chk("latency_out_valid", out_valid, 1);
    chk("in_ready_in_out", in_ready, 0);
  endtask

  task automatic drain_one();
    @(posedge clk);
    #1;
    chk("idle_after_handshake", busy, 0);
    chk("out_valid_cleared", out_valid, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int fw;
    vecs[0] = '{32'hA5A5A5A5, 32'hA5A5A5A5,  256, 1'b1};
    vecs[1] = '{32'hFFFFFFFF, 32'h00000000, -256, 1'b0};
    vecs[2] = '{32'h0000FFFF, 32'hFFFFFFFF,    0, 1'b1};
    vecs[3] = '{32'h00000000, 32'h0000000F,  192, 1'b1};
    vecs[4] = '{32'h00000000, 32'h000FFFFF,  -64, 1'b0};
    vecs[5] = '{32'hFFFFFFFE, 32'hFFFFFFFF,  240, 1'b1};
    vecs[6] = '{32'h00000000, 32'h00007FFF,   16, 1'b1};
    vecs[7] = '{32'h00000000, 32'h0001FFFF,  -16, 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_act = 'x; in_wgt = 'x; out_ready = 1'b1;
`ifdef XNOR_ACC_THRESH_EN
    thresh = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_bit", out_bit, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    rst = 1'b0;

    foreach (vecs[i]) begin
      push_exp(vecs[i].sum, vecs[i].b);
      send_frame(vecs[i].act, vecs[i].wgt, BEATS, 0, fw);
      after_frame();
      drain_one();
    end

    // Gapped input, then a 5-cycle output stall with the next beat waiting.
    out_ready = 1'b0;
    push_exp(256, 1'b1);
    send_frame(32'h12345678, 32'h12345678, BEATS, 1, fw);
    after_frame();
    in_valid = 1'b1; in_act = 32'hFFFFFFFF; in_wgt = 32'h0;
    for (int k = 0; k < 5; k++) begin
      chk("stall_out_valid", out_valid, 1);
      chk("stall_out_sum", out_sum, 256);
      chk("stall_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("release_in_ready", in_ready, 1);
    chk("release_out_valid", out_valid, 0);
    push_exp(-256, 1'b0);
    send_frame(32'hFFFFFFFF, 32'h0, BEATS, 0, fw);
    chk("next_frame_first_wait", fw, 1);
    after_frame();
    drain_one();

    // Abort a partial frame with reset; nothing may come out of it.
    send_frame(32'hFFFFFFFF, 32'hFFFFFFFF, 4, 0, fw);
    chk("partial_busy", busy, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_out_valid", out_valid, 0);
    push_exp(-256, 1'b0);
    send_frame(32'h0F0F0F0F, 32'hF0F0F0F0, BEATS, 0, fw);
    after_frame();
    drain_one();

`ifdef XNOR_ACC_THRESH_EN
    // 12 matches/beat -> -64; thresh changed after OUT entry must not matter.
    thresh = -10'sd64;
    push_exp(-64, 1'b1);
    send_frame(32'h0, 32'h000FFFFF, BEATS, 0, fw);
    thresh = 10'sd100;
    after_frame();
    drain_one();
    thresh = -10'sd63;
    push_exp(-64, 1'b0);
    send_frame(32'h0, 32'h000FFFFF, BEATS, 0, fw);
    thresh = -10'sd200;
    after_frame();
    drain_one();
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
